// File: rtl/lemming_swarm.sv
// lemming_swarm: N independent walk/fall/dig lemming FSMs with a live popcount.
// Define LEMMING_SWARM_SPLAT_EN to enable the fall counter and DEAD state.
module lemming_swarm #(
  parameter int N_LEM      = 4,
  parameter int FALL_LIMIT = 20,
  parameter int CNT_W      = $clog2(FALL_LIMIT + 1),
  parameter int POP_W      = $clog2(N_LEM + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_LEM-1:0] bump_left,
  input  logic [N_LEM-1:0] bump_right,
  input  logic [N_LEM-1:0] ground,
  input  logic [N_LEM-1:0] dig,
  output logic [N_LEM-1:0] walk_left,
  output logic [N_LEM-1:0] walk_right,
  output logic [N_LEM-1:0] aaah,
  output logic [N_LEM-1:0] digging,
  output logic [POP_W-1:0] alive_count,
  output logic             all_dead
);

  typedef enum logic [2:0] {
    WL    = 3'd0,
    WR    = 3'd1,
    FALLL = 3'd2,
    FALLR = 3'd3,
    DIGL  = 3'd4,
    DIGR  = 3'd5,
    DEAD  = 3'd6
  } state_t;

  state_t state    [N_LEM];
  state_t state_nx [N_LEM];

  // Per-channel state register; reset parks every lemming walking left.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_LEM; i++) begin
      if (reset) state[i] <= WL;
      else       state[i] <= state_nx[i];
    end
  end

`ifdef LEMMING_SWARM_SPLAT_EN
  logic [CNT_W-1:0] cnt [N_LEM];

  // Fall length counter: runs only while staying in a fall, saturates.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_LEM; i++) begin
      if (reset) begin
        cnt[i] <= '0;
      end else if ((state[i] == FALLL || state[i] == FALLR) &&
                   (state_nx[i] == FALLL || state_nx[i] == FALLR)) begin
        if (cnt[i] != CNT_W'(FALL_LIMIT))
          cnt[i] <= cnt[i] + CNT_W'(1);
      end else begin
        cnt[i] <= '0;
      end
    end
  end
`endif

  // Next-state logic: ground beats dig beats bump while walking.
  always_comb begin
    for (int i = 0; i < N_LEM; i++) begin
      state_nx[i] = state[i];
      case (state[i])
        WL: begin
          if (!ground[i])        state_nx[i] = FALLL;
          else if (dig[i])       state_nx[i] = DIGL;
          else if (bump_left[i]) state_nx[i] = WR;
        end
        WR: begin
          if (!ground[i])         state_nx[i] = FALLR;
          else if (dig[i])        state_nx[i] = DIGR;
          else if (bump_right[i]) state_nx[i] = WL;
        end
        DIGL: if (!ground[i]) state_nx[i] = FALLL;
        DIGR: if (!ground[i]) state_nx[i] = FALLR;
        FALLL: begin
          if (ground[i]) begin
`ifdef LEMMING_SWARM_SPLAT_EN
            if (cnt[i] >= CNT_W'(FALL_LIMIT)) state_nx[i] = DEAD;
            else                              state_nx[i] = WL;
`else
            state_nx[i] = WL;
`endif
          end
        end
        FALLR: begin
          if (ground[i]) begin
`ifdef LEMMING_SWARM_SPLAT_EN
            if (cnt[i] >= CNT_W'(FALL_LIMIT)) state_nx[i] = DEAD;
            else                              state_nx[i] = WR;
`else
            state_nx[i] = WR;
`endif
          end
        end
        DEAD:    state_nx[i] = DEAD;
        default: state_nx[i] = WL;
      endcase
    end
  end

  // Moore output decode; DEAD drives nothing.
  always_comb begin
    walk_left  = '0;
    walk_right = '0;
    aaah       = '0;
    digging    = '0;
    for (int i = 0; i < N_LEM; i++) begin
      walk_left[i]  = (state[i] == WL);
      walk_right[i] = (state[i] == WR);
      aaah[i]       = (state[i] == FALLL) || (state[i] == FALLR);
      digging[i]    = (state[i] == DIGL) || (state[i] == DIGR);
    end
  end

`ifdef LEMMING_SWARM_SPLAT_EN
  // Survivor popcount straight off the state registers.
  always_comb begin
    alive_count = '0;
    for (int i = 0; i < N_LEM; i++) begin
      if (state[i] != DEAD)
        alive_count = alive_count + POP_W'(1);
    end
    all_dead = (alive_count == '0);
  end
`else
  assign alive_count = POP_W'(N_LEM);
  assign all_dead    = 1'b0;
`endif

endmodule

// File: tb/tb_lemming_swarm.sv
// tb_lemming_swarm: directed checks for lemming_swarm (N_LEM=4, FALL_LIMIT=20).
// Expectations follow LEMMING_SWARM_SPLAT_EN when it is defined.
module tb_lemming_swarm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] bump_left, bump_right, ground, dig;
  logic [3:0] walk_left, walk_right, aaah, digging;
  logic [2:0] alive_count;
  logic       all_dead;

  int checks = 0;
  int failures = 0;

  lemming_swarm #(.N_LEM(4), .FALL_LIMIT(20)) dut (
    .clk(clk),
    .reset(reset),
    .bump_left(bump_left),
    .bump_right(bump_right),
    .ground(ground),
    .dig(dig),
    .walk_left(walk_left),
    .walk_right(walk_right),
    .aaah(aaah),
    .digging(digging),
    .alive_count(alive_count),
    .all_dead(all_dead)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    bump_left = '0;
    bump_right = '0;
    dig = '0;
    ground = 4'hF;
    tick(1);
    chk("rst_wl", walk_left, 4'hF);
    chk("rst_wr", walk_right, 4'h0);
    chk("rst_alive", alive_count, 3'd4);
    chk("rst_dead", all_dead, 1'b0);
    reset = 1'b0;
    tick(5);
    chk("idle_wl", walk_left, 4'hF);
    chk("idle_aaah", aaah, 4'h0);
    chk("idle_dig", digging, 4'h0);
    chk("idle_alive", alive_count, 3'd4);

    bump_left = 4'b0001;
    tick(1);
    bump_left = 4'b0010;
    chk("bump0_wr", walk_right, 4'b0001);
    chk("bump0_wl", walk_left, 4'b1110);
    tick(1);
    bump_left = '0;
    chk("bump1_wr", walk_right, 4'b0011);

    ground = 4'b1101;
    tick(1);
    chk("f20_first", aaah, 4'b0010);
    tick(19);
    chk("f20_last", aaah, 4'b0010);
    ground = 4'hF;
    tick(1);
    chk("f20_land_wr", walk_right, 4'b0011);
    chk("f20_land_aaah", aaah, 4'h0);
    chk("f20_alive", alive_count, 3'd4);

    ground = 4'b1101;
    tick(21);
    chk("f21_last", aaah, 4'b0010);
    ground = 4'hF;
    tick(1);
`ifdef LEMMING_SWARM_SPLAT_EN
    chk("f21_wr", walk_right, 4'b0001);
    chk("f21_outs", {walk_left[1], aaah[1], digging[1]}, 3'b000);
    chk("f21_alive", alive_count, 3'd3);
    for (int k = 0; k < 50; k++) begin
      ground     = {2'b11, 1'($urandom_range(0, 1)), 1'b1};
      dig        = {2'b00, 1'($urandom_range(0, 1)), 1'b0};
      bump_left  = {2'b00, 1'($urandom_range(0, 1)), 1'b0};
      bump_right = {2'b00, 1'($urandom_range(0, 1)), 1'b0};
      tick(1);
    end
    ground = 4'hF;
    dig = '0;
    bump_left = '0;
    bump_right = '0;
    tick(1);
    chk("dead_stays",
        {walk_left[1], walk_right[1], aaah[1], digging[1]}, 4'b0000);
    chk("dead_alive", alive_count, 3'd3);
`else
    chk("f21_wr", walk_right, 4'b0011);
    chk("f21_alive", alive_count, 3'd4);
`endif

    ground = 4'hF;
    dig = 4'b0100;
    bump_left = 4'b0100;
    tick(1);
    dig = '0;
    chk("prio_dig", digging, 4'b0100);
    chk("prio_dig_wl", walk_left[2], 1'b0);
    tick(1);
    bump_left = '0;
    chk("dig_bump_ign", digging, 4'b0100);
    ground = 4'b1011;
    tick(1);
    chk("dig_to_fall", aaah, 4'b0100);
    tick(2);
    ground = 4'hF;
    tick(1);
    chk("short_land", walk_left, 4'b1100);

    ground = 4'b0111;
    dig = 4'b1000;
    bump_left = 4'b1000;
    tick(1);
    chk("prio_fall", aaah, 4'b1000);
    ground = 4'hF;
    dig = '0;
    bump_left = '0;
    tick(1);
    chk("prio_fall_land", walk_left, 4'b1100);

    ground = 4'h0;
    tick(30);
`ifdef LEMMING_SWARM_SPLAT_EN
    chk("all_fall", aaah, 4'b1101);
    ground = 4'hF;
    tick(1);
    chk("all_dead_flag", all_dead, 1'b1);
    chk("all_dead_cnt", alive_count, 3'd0);
    chk("all_dead_wl", walk_left, 4'h0);
`else
    chk("all_fall", aaah, 4'hF);
    ground = 4'hF;
    tick(1);
    chk("all_land_flag", all_dead, 1'b0);
    chk("all_land_cnt", alive_count, 3'd4);
    chk("all_land_wl", walk_left, 4'b1100);
    chk("all_land_wr", walk_right, 4'b0011);
`endif
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rerst_wl", walk_left, 4'hF);
    chk("rerst_alive", alive_count, 3'd4);
    chk("rerst_flag", all_dead, 1'b0);

    ground = 4'h0;
    tick(10);
    chk("mid_fall", aaah, 4'hF);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("midrst_wl", walk_left, 4'hF);
    chk("midrst_aaah", aaah, 4'h0);
    tick(20);
    chk("post_fall", aaah, 4'hF);
    ground = 4'hF;
    tick(1);
    chk("post_land", walk_left, 4'hF);
    chk("post_alive", alive_count, 3'd4);

    bump_left = 4'b0001;
    tick(1);
    bump_left = '0;
    ground = 4'h0;
    tick(100);
    ground = 4'hF;
    tick(1);
`ifdef LEMMING_SWARM_SPLAT_EN
    chk("long_dead", all_dead, 1'b1);
    chk("long_alive", alive_count, 3'd0);
`else
    chk("long_wr", walk_right, 4'b0001);
    chk("long_wl", walk_left, 4'b1110);
    chk("long_alive", alive_count, 3'd4);
    chk("long_flag", all_dead, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
